// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame decoder.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DHI  = 3'd2,
    S_DLO  = 3'd3,
    S_CHK  = 3'd4
  } state_t;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int         FRAME_LEN      = 5;

endpackage

// File: rtl/uart_cmd_ctrl.sv
// Decodes 5-byte UART frames (HEADER ADDR DHI DLO CHK) into register-write strobes.
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
//
// state  | meaning
// S_IDLE | waiting for HEADER, other bytes dropped
// S_ADDR | expecting address byte
// S_DHI  | expecting data high byte
// S_DLO  | expecting data low byte
// S_CHK  | expecting checksum byte
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int         UART_BPS = 'd9600,
  parameter int         CLK_FREQ = 'd50_000_000,
  parameter logic [7:0] HEADER   = HEADER_DEFAULT
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  pi_data,
  input  logic        pi_flag,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        err_flag,
  output logic        busy
);

  state_t      state, state_nxt;
  logic [7:0]  csum, csum_nxt;
  logic [7:0]  addr_r, addr_nxt;
  logic [7:0]  dhi_r, dhi_nxt;
  logic [7:0]  dlo_r, dlo_nxt;
  logic        wr_en_nxt, err_nxt;
  logic [7:0]  wr_addr_nxt;
  logic [15:0] wr_data_nxt;

  assign busy = (state != S_IDLE);

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TIMEOUT_MAX = (CLK_FREQ / UART_BPS) * 20;
  logic [19:0] tcnt;
  logic        timeout_hit;

  assign timeout_hit = busy && (tcnt == 20'(TIMEOUT_MAX - 1));

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)                    tcnt <= '0;
    else if (pi_flag || !busy || timeout_hit) tcnt <= '0;
    else                               tcnt <= tcnt + 20'd1;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(CLK_FREQ), 32'(UART_BPS)};
`endif

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state    <= S_IDLE;
      csum     <= '0;
      addr_r   <= '0;
      dhi_r    <= '0;
      dlo_r    <= '0;
      wr_en    <= 1'b0;
      err_flag <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state    <= state_nxt;
      csum     <= csum_nxt;
      addr_r   <= addr_nxt;
      dhi_r    <= dhi_nxt;
      dlo_r    <= dlo_nxt;
      wr_en    <= wr_en_nxt;
      err_flag <= err_nxt;
      wr_addr  <= wr_addr_nxt;
      wr_data  <= wr_data_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    csum_nxt    = csum;
    addr_nxt    = addr_r;
    dhi_nxt     = dhi_r;
    dlo_nxt     = dlo_r;
    wr_en_nxt   = 1'b0;
    err_nxt     = 1'b0;
    wr_addr_nxt = wr_addr;
    wr_data_nxt = wr_data;
    // A byte arriving together with a timeout takes priority
    if (pi_flag) begin
      case (state)
        S_IDLE: if (pi_data == HEADER) begin
          state_nxt = S_ADDR;
          csum_nxt  = '0;
        end
        S_ADDR: begin
          addr_nxt  = pi_data;
          csum_nxt  = csum + pi_data;
          state_nxt = S_DHI;
        end
        S_DHI: begin
          dhi_nxt   = pi_data;
          csum_nxt  = csum + pi_data;
          state_nxt = S_DLO;
        end
        S_DLO: begin
          dlo_nxt   = pi_data;
          csum_nxt  = csum + pi_data;
          state_nxt = S_CHK;
        end
        S_CHK: begin
          state_nxt = S_IDLE;
          if (pi_data == csum) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = addr_r;
            wr_data_nxt = {dhi_r, dlo_r};
          end else begin
            err_nxt = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
`ifdef UART_CMD_TIMEOUT_EN
    else if (timeout_hit) begin
      state_nxt = S_IDLE;
      err_nxt   = 1'b1;
    end
`endif
  end

endmodule
